// File: rtl/mem_port_sched.sv
// Serialises the EX/MEM slot A and slot B memory accesses onto a single-ported
// req/ack data bus in program order, capturing read data per slot and stalling the pipeline meanwhile.
module mem_port_sched #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                a_ce,
  input  logic                b_ce,
  input  logic                a_we,
  input  logic                b_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic [DATA_W-1:0]   b_wdata,
  input  logic [DATA_W/8-1:0] a_sel,
  input  logic [DATA_W/8-1:0] b_sel,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_sel,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic [DATA_W-1:0]   a_rdata,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                stall_req
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ_A = 2'd1,
    REQ_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                abort_q, abort_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      abort_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      abort_q   <= abort_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    abort_d   = abort_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_sel   = '0;
    stall_req = 1'b0;

    case (state_q)
      IDLE: begin
        abort_d   = 1'b0;
        stall_req = (a_ce | b_ce) & ~flush;
        if (flush)     state_d = IDLE;
        else if (a_ce) state_d = REQ_A;
        else if (b_ce) state_d = REQ_B;
        else           state_d = IDLE;
      end

      REQ_A: begin
        bus_req   = 1'b1;
        bus_we    = a_we;
        bus_addr  = a_addr;
        bus_wdata = a_wdata;
        bus_sel   = a_sel;
        stall_req = 1'b1;
        // A beat in flight is never withdrawn; a flush only cancels what follows it.
        if (flush) abort_d = 1'b1;
        if (bus_ack) begin
          if (!a_we) a_rdata_d = bus_rdata;
          if (abort_q | flush) begin
            state_d = IDLE;
            abort_d = 1'b0;
          end else if (b_ce) begin
            state_d = REQ_B;
          end else begin
            state_d = DONE;
          end
        end
      end

      REQ_B: begin
        bus_req   = 1'b1;
        bus_we    = b_we;
        bus_addr  = b_addr;
        bus_wdata = b_wdata;
        bus_sel   = b_sel;
        stall_req = 1'b1;
        if (flush) abort_d = 1'b1;
        if (bus_ack) begin
          if (!b_we) b_rdata_d = bus_rdata;
          if (abort_q | flush) begin
            state_d = IDLE;
            abort_d = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // Single release cycle so the pipeline consumes a_rdata/b_rdata.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        abort_d = 1'b0;
      end
    endcase
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule
